// File: rtl/fir_axil_regs.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_axil_regs : AXI4-Lite register file for the FIR control plane.       |
// | Optional macro FIR_AXIL_SLVERR_EN : SLVERR on out-of-range accesses.     |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module fir_axil_regs #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_REGS   = 4
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [3:0]                     S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int         IDX_W       = ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wstate_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    wstate_t               r_wstate, w_wstate_nxt;
    rstate_t               r_rstate, w_rstate_nxt;
    logic                  r_ready_en;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_wstrb;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_wr_pulse, w_wr_sel;
    logic [1:0]            r_bresp, w_bresp, r_rresp, w_rresp;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata;
    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [3:0]            w_wr_strb;
    logic [IDX_W-1:0]      w_wr_idx, w_rd_idx;
    logic                  w_wr_in_range, w_rd_in_range;
    logic                  w_unused;

    // Readies stay low until the first clock edge after reset release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_ready_en <= 1'b0;
        else          r_ready_en <= 1'b1;
    end

    assign S_AXI_AWREADY = r_ready_en && (r_wstate == W_IDLE || r_wstate == W_HAVE_W);
    assign S_AXI_WREADY  = r_ready_en && (r_wstate == W_IDLE || r_wstate == W_HAVE_AW);
    assign S_AXI_BVALID  = (r_wstate == W_RESP);
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_ready_en && (r_rstate == R_IDLE);
    assign S_AXI_RVALID  = (r_rstate == R_DATA);
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign reg_wr_pulse  = r_wr_pulse;

    assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    assign w_wr_addr     = (r_wstate == W_HAVE_AW) ? r_awaddr : S_AXI_AWADDR;
    assign w_wr_data     = (r_wstate == W_HAVE_W)  ? r_wdata  : S_AXI_WDATA;
    assign w_wr_strb     = (r_wstate == W_HAVE_W)  ? r_wstrb  : S_AXI_WSTRB;
    assign w_wr_idx      = w_wr_addr[ADDR_WIDTH-1:2];
    assign w_rd_idx      = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign w_wr_in_range = (32'(w_wr_idx) < NUM_REGS);
    assign w_rd_in_range = (32'(w_rd_idx) < NUM_REGS);

`ifdef FIR_AXIL_SLVERR_EN
    assign w_bresp = w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
`else
    assign w_bresp = RESP_OKAY;
`endif

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_commit     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_wstate_nxt = W_RESP;
                    w_commit     = 1'b1;
                end else if (w_aw_hs) begin
                    w_wstate_nxt = W_HAVE_AW;
                end else if (w_w_hs) begin
                    w_wstate_nxt = W_HAVE_W;
                end
            end
            W_HAVE_AW: if (w_w_hs) begin
                w_wstate_nxt = W_RESP;
                w_commit     = 1'b1;
            end
            W_HAVE_W: if (w_aw_hs) begin
                w_wstate_nxt = W_RESP;
                w_commit     = 1'b1;
            end
            W_RESP: if (S_AXI_BREADY) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wr_sel[i] = w_commit && w_wr_in_range && (w_wr_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate   <= W_IDLE;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_wstate   <= w_wstate_nxt;
            r_wr_pulse <= w_wr_sel;
            if (w_aw_hs) r_awaddr <= S_AXI_AWADDR;
            if (w_w_hs) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
            if (w_commit) r_bresp <= w_bresp;
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_wr_sel[i] && w_wr_strb[b]) r_regs[i][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
`ifdef FIR_AXIL_SLVERR_EN
        w_rdata = 32'hDEAD_BEEF;
        w_rresp = RESP_SLVERR;
`else
        w_rdata = '0;
        w_rresp = RESP_OKAY;
`endif
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_in_range && w_rd_idx == IDX_W'(i)) begin
                w_rdata = r_regs[i];
                w_rresp = RESP_OKAY;
            end
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (S_AXI_RREADY) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read data is sampled from the pre-edge register array, so a colliding write is not seen.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_ar_hs) begin
                r_rdata <= w_rdata;
                r_rresp <= w_rresp;
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
            assign reg_q[DATA_WIDTH*i +: DATA_WIDTH] = r_regs[i];
        end
    endgenerate

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_fir_axil_regs.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fir_axil_regs : scoreboard bench for the FIR AXI4-Lite register file. |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module tb_fir_axil_regs;

    localparam int NR = 4;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [5:0]    AWADDR = '0;
    logic [2:0]    AWPROT = '0;
    logic          AWVALID = 1'b0;
    logic          AWREADY;
    logic [31:0]   WDATA = '0;
    logic [3:0]    WSTRB = '0;
    logic          WVALID = 1'b0;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY = 1'b0;
    logic [5:0]    ARADDR = '0;
    logic [2:0]    ARPROT = '0;
    logic          ARVALID = 1'b0;
    logic          ARREADY;
    logic [31:0]   RDATA;
    logic [1:0]    RRESP;
    logic          RVALID;
    logic          RREADY = 1'b0;
    logic [127:0]  reg_q;
    logic [NR-1:0] reg_wr_pulse;

    always #5 ACLK = ~ACLK;

    fir_axil_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REGS(NR)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
        .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
    );

    int            n_checks = 0;
    int            n_fail = 0;
    logic [31:0]   model [NR];
    logic [1:0]    bq [$];
    logic [33:0]   rq [$];
    logic [NR-1:0] pq [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int i = 0; i < NR; i++) f[32*i +: 32] = model[i];
        return f;
    endfunction

    // Expected {resp, data} for a read of the given byte address.
    function automatic logic [33:0] read_expect(input logic [5:0] addr);
        int idx;
        idx = int'(addr) / 4;
        if (idx < NR) return {2'b00, model[idx]};
`ifdef FIR_AXIL_SLVERR_EN
        return {2'b10, 32'hDEADBEEF};
`else
        return 34'd0;
`endif
    endfunction

    task automatic model_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        logic [NR-1:0] onehot;
        idx = int'(addr) / 4;
        if (idx < NR) begin
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
            onehot = '0;
            onehot[idx] = 1'b1;
            pq.push_back(onehot);
            bq.push_back(2'b00);
        end else begin
`ifdef FIR_AXIL_SLVERR_EN
            bq.push_back(2'b10);
`else
            bq.push_back(2'b00);
`endif
        end
    endtask

    // Monitor: pops expectations whenever the DUT completes a response or pulses.
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (BVALID && BREADY) begin
                if (bq.size() == 0) check("b_unexpected", BVALID, 0);
                else check("bresp", BRESP, bq.pop_front());
            end
            if (RVALID && RREADY) begin
                if (rq.size() == 0) check("r_unexpected", RVALID, 0);
                else begin
                    logic [33:0] e;
                    e = rq.pop_front();
                    check("rdata", RDATA, e[31:0]);
                    check("rresp", RRESP, e[33:32]);
                end
            end
            if (reg_wr_pulse != '0) begin
                if (pq.size() == 0) check("pulse_unexpected", reg_wr_pulse, 0);
                else check("wr_pulse", reg_wr_pulse, pq.pop_front());
            end
        end
    end

    // w_lead > 0: W leads AW by w_lead cycles; w_lead < 0: AW leads W.
    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, input int b_delay);
        int aw_at, w_at, cyc, n;
        bit aw_done, w_done, aw_rdy, w_rdy;
        aw_at = (w_lead > 0) ? w_lead : 0;
        w_at  = (w_lead < 0) ? -w_lead : 0;
        model_write(addr, data, strb);
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done)) begin
            AWADDR  = addr;
            WDATA   = data;
            WSTRB   = strb;
            AWVALID = !aw_done && (cyc >= aw_at);
            WVALID  = !w_done && (cyc >= w_at);
            @(negedge ACLK);
            aw_rdy = AWREADY;
            w_rdy  = WREADY;
            if (w_done && !aw_done) check("wready_low_after_w", WREADY, 0);
            if (aw_done && !w_done) check("awready_low_after_aw", AWREADY, 0);
            @(posedge ACLK);
            if (AWVALID && aw_rdy) aw_done = 1;
            if (WVALID && w_rdy) w_done = 1;
            #1;
            cyc++;
            if (cyc > 40) begin
                check("write_handshake_timeout", 0, 1);
                break;
            end
        end
        AWVALID = 0;
        WVALID  = 0;
        @(negedge ACLK);
        check("bvalid_latency", BVALID, 1);
        for (int k = 0; k < b_delay; k++) begin
            @(posedge ACLK); #1;
            @(negedge ACLK);
            check("bvalid_stall", BVALID, 1);
            check("awready_stall", AWREADY, 0);
            check("wready_stall", WREADY, 0);
        end
        @(posedge ACLK); #1;
        BREADY = 1;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!BVALID && n < 20);
        if (!BVALID) check("b_timeout", BVALID, 1);
        @(posedge ACLK); #1;
        BREADY = 0;
        check("awready_after_b", AWREADY, 1);
        check("reg_q", reg_q, model_flat());
    endtask

    task automatic axi_read(input logic [5:0] addr, input int r_delay, input logic [33:0] exp);
        int n;
        bit rdy, done;
        rq.push_back(exp);
        ARADDR  = addr;
        ARVALID = 1;
        done = 0; n = 0;
        while (!done) begin
            @(negedge ACLK);
            rdy = ARREADY;
            @(posedge ACLK);
            if (rdy) done = 1;
            #1;
            n++;
            if (!done && n > 40) begin
                check("read_handshake_timeout", 0, 1);
                break;
            end
        end
        ARVALID = 0;
        @(negedge ACLK);
        check("rvalid_latency", RVALID, 1);
        for (int k = 0; k < r_delay; k++) begin
            @(posedge ACLK); #1;
            @(negedge ACLK);
            check("rvalid_stall", RVALID, 1);
            check("arready_stall", ARREADY, 0);
            check("rdata_stall", RDATA, exp[31:0]);
        end
        @(posedge ACLK); #1;
        RREADY = 1;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!RVALID && n < 20);
        if (!RVALID) check("r_timeout", RVALID, 1);
        @(posedge ACLK); #1;
        RREADY = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] e;
        int n;
        for (int i = 0; i < NR; i++) model[i] = '0;

        repeat (3) @(posedge ACLK);
        #1;
        check("rst_awready", AWREADY, 0);
        check("rst_wready", WREADY, 0);
        check("rst_arready", ARREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_reg_q", reg_q, 0);
        check("rst_pulse", reg_wr_pulse, 0);
        @(negedge ACLK);
        ARESETN = 1;
        #1;
        check("awready_before_first_edge", AWREADY, 0);
        @(posedge ACLK); #1;
        check("awready_after_release", AWREADY, 1);
        check("wready_after_release", WREADY, 1);
        check("arready_after_release", ARREADY, 1);

        for (int i = 0; i < NR; i++) axi_write(6'(4 * i), 32'(i + 1), 4'hF, 0, 0);
        for (int i = 0; i < NR; i++) axi_read(6'(4 * i), 0, {2'b00, 32'(i + 1)});

        axi_write(6'h04, 32'hA5A5A5A5, 4'hF, 3, 0);
        check("reg1_after_w_first", reg_q[63:32], 32'hA5A5A5A5);
        axi_write(6'h0C, 32'h0BADF00D, 4'hF, -2, 0);

        axi_write(6'h00, 32'h11223344, 4'hF, 0, 0);
        axi_write(6'h00, 32'hAABBCCDD, 4'b0101, 0, 0);
        axi_read(6'h00, 0, {2'b00, 32'h11BB33DD});

        axi_write(6'h08, 32'h12345678, 4'hF, 0, 5);
        axi_read(6'h08, 5, {2'b00, 32'h12345678});

        axi_write(6'h20, 32'hFFFFFFFF, 4'hF, 0, 0);
        axi_read(6'h20, 0, read_expect(6'h20));
        axi_write(6'h0E, 32'h00C0FFEE, 4'hF, 1, 0);
        axi_read(6'h0D, 0, {2'b00, 32'h00C0FFEE});
        axi_write(6'h04, 32'hFFFFFFFF, 4'h0, 0, 0);

        e = read_expect(6'h04);
        fork
            axi_write(6'h04, 32'hCAFEF00D, 4'hF, 0, 0);
            axi_read(6'h04, 0, e);
        join
        axi_read(6'h04, 0, {2'b00, 32'hCAFEF00D});

        for (int it = 0; it < 60; it++) begin
            logic [5:0] a;
            a = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                          int'($urandom_range(0, 3)));
            else
                axi_read(a, int'($urandom_range(0, 3)), read_expect(a));
        end

        axi_write(6'h08, 32'h5, 4'hF, 0, 0);
        axi_read(6'h08, 0, {2'b00, 32'h5});
        AWADDR  = 6'h08;
        AWVALID = 1;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!AWREADY && n < 20);
        @(posedge ACLK); #1;
        AWVALID = 0;
        check("have_aw_wready", WREADY, 1);
        #1;
        ARESETN = 0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        #1;
        check("mid_rst_awready", AWREADY, 0);
        check("mid_rst_wready", WREADY, 0);
        check("mid_rst_arready", ARREADY, 0);
        check("mid_rst_bvalid", BVALID, 0);
        check("mid_rst_rvalid", RVALID, 0);
        check("mid_rst_bresp", BRESP, 0);
        check("mid_rst_rresp", RRESP, 0);
        check("mid_rst_rdata", RDATA, 0);
        check("mid_rst_pulse", reg_wr_pulse, 0);
        check("mid_rst_reg_q", reg_q, 0);
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1;
        @(posedge ACLK); #1;
        axi_read(6'h08, 0, 34'd0);

        repeat (3) @(posedge ACLK);
        #1;
        check("bq_drained", bq.size(), 0);
        check("rq_drained", rq.size(), 0);
        check("pq_drained", pq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_axil_regs.md
Name: fir_axil_regs

Overview:
AXI4-Lite slave register file that terminates the control-plane bus of the FIR IP. It is the responder end of the master VIP's AXI4LITE_WRITE_BURST / AXI4LITE_READ_BURST traffic. It holds NUM_REGS 32-bit registers (coefficient/control words), exposes them flat to the FIR datapath, and produces a one-cycle update pulse per register on every accepted write.

Parameters:
- DATA_WIDTH, 32: bus/register width; only 32 is supported.
- ADDR_WIDTH, 6: byte-address width; word index = addr[ADDR_WIDTH-1:2].
- NUM_REGS, 4: implemented registers at 0x00, 0x04, ...; indices >= NUM_REGS are out of range.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset, asynchronous active-low.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake.
- reg_q  out  NUM_REGS*32  register contents; reg i at [32i+31:32i].
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse, bit i set the cycle after reg i is updated.

Behaviour:
- Reset (ARESETN=0, async): all registers 0.
  - AWREADY, WREADY, ARREADY, BVALID and RVALID are 0.
  - BRESP, RRESP, RDATA are 0; reg_wr_pulse is 0.
  - AWREADY, WREADY and ARREADY rise on the first ACLK edge after release.
- Write FSM, states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP:
  - W_IDLE: AWREADY=WREADY=1.
    - AW and W in the same cycle -> W_RESP.
    - AW only -> latch address, W_HAVE_AW (AWREADY drops).
    - W only -> latch data and strobes, W_HAVE_W (WREADY drops).
  - W_HAVE_AW / W_HAVE_W: wait for the missing channel, then go to W_RESP.
  - Entering W_RESP: the register is updated with a byte-wise WSTRB merge, and BVALID=1, BRESP=OKAY on the next cycle. Latency from the later of the AW/W handshakes to BVALID is 1 cycle.
  - W_RESP: AWREADY=WREADY=0; BVALID holds until BREADY; then back to W_IDLE with both readies 1 on the next cycle.
  - reg_wr_pulse[i] asserts the cycle after the update, even if WSTRB=0.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: ARREADY=1. On AR handshake, capture reg[index] into RDATA (RRESP=OKAY); RVALID=1 the next cycle; ARREADY=0.
  - R_DATA: RDATA/RRESP/RVALID held stable until RREADY, then back to R_IDLE.
  - Read latency: 1 cycle.
- Read and write channels are fully independent. A read and a write to the same register in the same cycle: the read returns the pre-write value.
- Out-of-range write: no register changes, no pulse, BRESP=OKAY. Out-of-range read: RDATA=0, RRESP=OKAY.
- Unaligned addresses: addr[1:0] ignored.
- Reset mid-transaction: all pending handshakes are abandoned, FSMs go to IDLE, and no partial write is committed.

Optional Feature:
- Macro: FIR_AXIL_SLVERR_EN.
- Defined: out-of-range write returns BRESP=SLVERR (2'b10) and no update. Out-of-range read returns RRESP=SLVERR with RDATA=0xDEADBEEF.
- Undefined: OKAY responses as described above; the SLVERR path is not synthesised.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x00/0x04/0x08/0x0C, then read back in order -> RDATA 0x1..0x4, all BRESP/RRESP=OKAY, reg_wr_pulse bits 0..3 each pulse once.
- W presented 3 cycles before AW to 0x04 with data 0xA5A5A5A5 -> WREADY low after the W handshake; BVALID 1 cycle after the AW handshake; reg_q[63:32]=0xA5A5A5A5.
- Reg0=0x11223344, then write 0xAABBCCDD with WSTRB=4'b0101 -> read returns 0x11BB33DD.
- BREADY held low 5 cycles after a write -> BVALID stays 1, AWREADY/WREADY stay 0 and a second AW is not accepted until the B handshake. Same check for RREADY held low on RVALID/RDATA.
- Write 0xFFFFFFFF to 0x20 (index 8) -> reg_q unchanged, no pulse; BRESP=OKAY without the macro, SLVERR with FIR_AXIL_SLVERR_EN. Read 0x20 -> 0 with OKAY, or 0xDEADBEEF with SLVERR.
- Deassert ARESETN while in W_HAVE_AW after loading reg2=0x5 -> all outputs 0 immediately, reg_q=0; after release, reading 0x08 returns 0.
